// File: rtl/ring_oscillator_pkg.sv
// Shared constants and helpers for the ring oscillator cells.
// Legal stage-count range and a clamp so an out-of-range n never builds a zero-width ring.
package ring_oscillator_pkg;

  localparam int RO_N_MIN = 1;
  localparam int RO_N_MAX = 64;

  function automatic int ro_clamp_n(input int n);
    if (n < RO_N_MIN) return RO_N_MIN;
    if (n > RO_N_MAX) return RO_N_MAX;
    return n;
  endfunction

endpackage

// File: rtl/ring_oscillator_stage.sv
// One clocked delay element of the ring; stage 0 carries the single loop inversion.
module ro_stage #(
  parameter bit invert = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (enable) q_d = d ^ invert;
  end

  // Reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ring_oscillator.sv
// n-stage Johnson-style ring: clocked stages closed through one inverter, period 2n enabled clocks.
// out is the last stage, so it is registered with no path from any input.
module ring_oscillator
  import ring_oscillator_pkg::*;
#(
  parameter int n = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic out
);

  localparam int N_STAGES = ro_clamp_n(n);

  logic [N_STAGES-1:0] stage;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      ro_stage #(.invert(1'b1)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (stage[N_STAGES-1]),
        .q      (stage[0])
      );
    end else begin : g_tail
      ro_stage #(.invert(1'b0)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (stage[k-1]),
        .q      (stage[k])
      );
    end
  end

  assign out = stage[N_STAGES-1];

endmodule

// File: tb/tb_ring_oscillator.sv
// Bench for ring_oscillator: instances n=1..9 on one clock, phase-count model plus directed literals.
module tb_ring_oscillator;

  localparam int NI = 9;  // instance j has n = j+1

  logic clk;
  logic rst;
  logic enable;
  logic [NI-1:0] outs;

  int checks = 0;
  int passes = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ring_oscillator #(.n(g + 1)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .out    (outs[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: enabled edges since reset, modulo the period; out is high in the second half.
  int  phase [NI];
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b1;
      for (int j = 0; j < NI; j++) phase[j] <= 0;
    end else if (enable && model_valid) begin
      for (int j = 0; j < NI; j++) phase[j] <= (phase[j] + 1) % (2 * (j + 1));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (outs[j] === ((phase[j] >= (j + 1)) ? 1'b1 : 1'b0)) passes++;
        else $display("FAIL model_n%0d: got %b expected %b (phase %0d)",
                      j + 1, outs[j], (phase[j] >= (j + 1)), phase[j]);
      end
    end
  end

  task automatic tick(input logic r, input logic e);
    rst    = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  int lit_n3 [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int lit_n1 [4]  = '{1, 0, 1, 0};
  int lit_n5 [5]  = '{0, 0, 0, 0, 1};
  int rise1 [NI];
  int rise2 [NI];
  int fall1 [NI];
  logic [NI-1:0] prev;

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    #2;

    // Reset with enable high
    tick(1'b1, 1'b1);
    for (int j = 0; j < NI; j++) chk($sformatf("reset_out_n%0d", j + 1), int'(outs[j]), 0);

    // Free run, n=3 and n=1 literal waveforms
    for (int e = 0; e < 12; e++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("n3_edge%0d", e + 1), int'(outs[2]), lit_n3[e]);
      if (e < 4) chk($sformatf("n1_edge%0d", e + 1), int'(outs[0]), lit_n1[e]);
    end

    // Mid-cycle reset: n=3 is in its high phase after 4 more edges
    for (int e = 0; e < 4; e++) tick(1'b0, 1'b1);
    chk("n3_high_before_reset", int'(outs[2]), 1);
    tick(1'b1, 1'b1);
    for (int j = 0; j < NI; j++) chk($sformatf("midreset_out_n%0d", j + 1), int'(outs[j]), 0);

    // Period sweep across n=2..9
    for (int j = 0; j < NI; j++) begin
      rise1[j] = 0; rise2[j] = 0; fall1[j] = 0;
    end
    prev = '0;
    for (int e = 1; e <= 40; e++) begin
      tick(1'b0, 1'b1);
      for (int j = 0; j < NI; j++) begin
        if (!prev[j] && outs[j]) begin
          if (rise1[j] == 0) rise1[j] = e;
          else if (rise2[j] == 0) rise2[j] = e;
        end
        if (prev[j] && !outs[j] && fall1[j] == 0) fall1[j] = e;
      end
      prev = outs;
    end
    for (int j = 1; j < NI; j++) begin
      chk($sformatf("first_rise_n%0d", j + 1), rise1[j], j + 1);
      chk($sformatf("period_n%0d", j + 1), rise2[j] - rise1[j], 2 * (j + 1));
      chk($sformatf("high_time_n%0d", j + 1), fall1[j] - rise1[j], j + 1);
    end

    // Enable hold, n=4
    tick(1'b1, 1'b1);
    for (int e = 0; e < 5; e++) tick(1'b0, 1'b1);
    chk("n4_after5", int'(outs[3]), 1);
    for (int e = 0; e < 3; e++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("n4_hold%0d", e + 1), int'(outs[3]), 1);
    end
    tick(1'b0, 1'b1);
    chk("n4_edge6", int'(outs[3]), 1);
    tick(1'b0, 1'b1);
    chk("n4_edge7", int'(outs[3]), 1);
    tick(1'b0, 1'b1);
    chk("n4_edge8_fall", int'(outs[3]), 0);

    // Reset priority in the middle of n=4's high phase
    for (int e = 0; e < 5; e++) tick(1'b0, 1'b1);
    chk("n4_high_before_prio", int'(outs[3]), 1);
    tick(1'b1, 1'b1);
    chk("n4_reset_prio", int'(outs[3]), 0);
    for (int e = 0; e < 5; e++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("n5_restart_edge%0d", e + 1), int'(outs[4]), lit_n5[e]);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
